// File: rtl/demorgan_sweep_checker_pkg.sv
// Shared state encoding and constants for the De Morgan sweep checker.
package demorgan_chk_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam int   NUM_VECTORS    = 4;
   localparam logic TYPE_NOR_FORM  = 1'b0;
   localparam logic TYPE_NAND_FORM = 1'b1;

endpackage

// File: rtl/demorgan_sweep_checker_if.sv
// Control, gate-drive and result signals of the sweep checker.
interface demorgan_sweep_checker_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic             type_sel;
   logic             dut_c;
   logic             dut_a;
   logic             dut_b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output start, type_sel, dut_c,
      input  dut_a, dut_b, busy, done, pass, err_cnt
   );

   modport slave (
      input  start, type_sel, dut_c,
      output dut_a, dut_b, busy, done, pass, err_cnt
   );
endinterface

// File: rtl/demorgan_sweep_checker_ref_model.sv
// Golden expected output of a two-input De Morgan gate for the selected form.
module demorgan_ref_model
   import demorgan_chk_pkg::*;
(
   input  logic i_a,
   input  logic i_b,
   input  logic i_type,
   output logic o_c
);

   assign o_c = (i_type == TYPE_NAND_FORM) ? ~(i_a & i_b) : ~(i_a | i_b);

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Exhaustive a/b sweep of a De Morgan gate with settle, compare and saturating error count.
// DEMORGAN_CHK_HALT_ON_ERR_EN: end the run on the first mismatch.
module demorgan_sweep_checker
   import demorgan_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1,
   parameter int ERR_W         = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   demorgan_sweep_checker_if.slave io_chk
);

   localparam int PW = $clog2(PASSES + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   logic [1:0]       r_state;
   logic [1:0]       r_vec;
   logic [PW-1:0]    r_pass_idx;
   logic [SW-1:0]    r_settle;
   logic             r_type;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err_cnt;

   logic             w_exp;
   logic             w_mismatch;
   logic             w_last;
   logic             w_end;
   logic [ERR_W-1:0] w_err_next;

   demorgan_ref_model u_ref (
      .i_a    (r_vec[1]),
      .i_b    (r_vec[0]),
      .i_type (r_type),
      .o_c    (w_exp)
   );

   assign w_mismatch = (io_chk.dut_c != w_exp);
   assign w_last     = (r_vec == 2'(NUM_VECTORS - 1)) && (r_pass_idx == PW'(PASSES - 1));
   assign w_err_next = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;

`ifdef DEMORGAN_CHK_HALT_ON_ERR_EN
   assign w_end = w_last || w_mismatch;
`else
   assign w_end = w_last;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_vec      <= '0;
         r_pass_idx <= '0;
         r_settle   <= '0;
         r_type     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (io_chk.start) begin
                  r_state    <= ST_SETTLE;
                  r_vec      <= '0;
                  r_pass_idx <= '0;
                  r_settle   <= '0;
                  r_err_cnt  <= '0;
                  r_pass     <= 1'b0;
                  r_type     <= io_chk.type_sel;
                  r_busy     <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                  r_state  <= ST_SAMPLE;
                  r_settle <= '0;
               end else begin
                  r_settle <= r_settle + SW'(1);
               end
            end
            ST_SAMPLE: begin
               r_err_cnt <= w_err_next;
               if (w_end) begin
                  // Vector is parked at 0 so the gate sees 00 once idle.
                  r_state <= ST_DONE;
                  r_vec   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_state <= ST_SETTLE;
                  r_vec   <= r_vec + 2'd1;
                  if (r_vec == 2'(NUM_VECTORS - 1))
                     r_pass_idx <= r_pass_idx + PW'(1);
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign io_chk.dut_a   = r_vec[1];
   assign io_chk.dut_b   = r_vec[0];
   assign io_chk.busy    = r_busy;
   assign io_chk.done    = r_done;
   assign io_chk.pass    = r_pass;
   assign io_chk.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Randomized runs of the sweep checker against a per-run reference computed from the gate rules.
module tb_demorgan_sweep_checker;

   localparam int S  = 2;
   localparam int P  = 2;
   localparam int EW = 3;
   localparam int MAX_CYC = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int n_total = 0;
   int n_bad   = 0;

   // Gate behaviour selected per run: 0 correct NAND, 1 tied 0, 2 wrong everywhere, 3 NAND wrong at ab=10
   int   run_mode = 0;
   logic run_type = 1'b1;

   demorgan_sweep_checker_if #(.ERR_W(EW)) chk_if ();

   demorgan_sweep_checker #(
      .SETTLE_CYCLES (S),
      .PASSES        (P),
      .ERR_W         (EW)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_chk (chk_if.slave)
   );

   always #5 clk = ~clk;

   function automatic bit spec_c(input bit t, input bit a, input bit b);
      return t ? !(a && b) : !(a || b);
   endfunction

   function automatic bit gate_c(input int mode, input bit t, input bit a, input bit b);
      case (mode)
         0:       return !(a && b);
         1:       return 1'b0;
         2:       return !spec_c(t, a, b);
         default: return (a && !b) ? 1'b0 : !(a && b);
      endcase
   endfunction

   always_comb chk_if.dut_c = gate_c(run_mode, run_type, chk_if.dut_a, chk_if.dut_b);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected error count and number of vectors visited for one run.
   task automatic predict(input bit t, input int mode, output int exp_err, output int exp_vecs);
      bit stop;
      exp_err  = 0;
      exp_vecs = 0;
      stop     = 1'b0;
      for (int p = 0; p < P && !stop; p++) begin
         for (int v = 0; v < 4 && !stop; v++) begin
            bit a, b;
            a = v[1];
            b = v[0];
            exp_vecs++;
            if (gate_c(mode, t, a, b) != spec_c(t, a, b)) begin
               if (exp_err < (2 ** EW) - 1) exp_err++;
`ifdef DEMORGAN_CHK_HALT_ON_ERR_EN
               stop = 1'b1;
`endif
            end
         end
      end
   endtask

   task automatic do_run(input bit t, input int mode);
      int exp_err, exp_vecs, k;
      run_type = t;
      run_mode = mode;
      predict(t, mode, exp_err, exp_vecs);
      @(negedge clk);
      chk_if.type_sel = t;
      chk_if.start    = 1'b1;
      @(negedge clk);
      k = 0;
      while (chk_if.busy === 1'b1 && k < MAX_CYC) begin
         chk("vec", {30'd0, chk_if.dut_a, chk_if.dut_b}, 32'((k / (S + 1)) % 4));
         chk_if.type_sel = 1'($urandom);
         chk_if.start    = 1'($urandom);
         @(negedge clk);
         k++;
      end
      chk_if.start = 1'b0;
      chk("busy_len", k, exp_vecs * (S + 1));
      chk("done", {31'd0, chk_if.done}, 1);
      chk("pass", {31'd0, chk_if.pass}, (exp_err == 0) ? 1 : 0);
      chk("err_cnt", {29'd0, chk_if.err_cnt}, exp_err);
      @(negedge clk);
      chk("done_off", {31'd0, chk_if.done}, 0);
      chk("idle_ab", {30'd0, chk_if.dut_a, chk_if.dut_b}, 0);
   endtask

   function automatic logic [31:0] all_outs();
      return {24'd0, chk_if.busy, chk_if.done, chk_if.pass, chk_if.dut_a, chk_if.dut_b, chk_if.err_cnt};
   endfunction

   initial begin
      chk_if.start    = 1'b0;
      chk_if.type_sel = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outs", all_outs(), 0);
      rst_n = 1'b1;

      do_run(1'b1, 0);
      do_run(1'b0, 0);
      do_run(1'b1, 1);
      do_run(1'b1, 2);
      do_run(1'b1, 3);
      do_run(1'b0, 2);

      for (int i = 0; i < 12; i++)
         do_run(1'($urandom), int'($urandom_range(0, 3)));

      // Abort mid-run after an error has been counted.
      run_type = 1'b1;
      run_mode = 1;
      @(negedge clk);
      chk_if.type_sel = 1'b1;
      chk_if.start    = 1'b1;
      @(negedge clk);
      chk_if.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_abort_err", {29'd0, chk_if.err_cnt}, 1);
      #2 rst_n = 1'b0;
      #1 chk("abort_outs", all_outs(), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, chk_if.done}, 0);
      end
      rst_n = 1'b1;
      do_run(1'b1, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/demorgan_sweep_checker.md
# demorgan_sweep_checker

Synthesizable self-checking stimulus/response engine for the two-input De Morgan gate blocks. On `start`, it drives an exhaustive sweep of the gate inputs `a`/`b` in the order 00, 01, 10, 11, with `b` toggling fastest. After a programmable settle time it samples the gate output `c` and compares it against the expected value for the selected De Morgan form. It reports an error count and a pass/fail verdict, so gate checks can run on hardware without a simulator testbench.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range ≥1.
- `PASSES`, default 1: number of complete 4-vector sweeps per run; legal range ≥1.
- `ERR_W`, default 8: width of the error counter.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: run request; sampled only in IDLE.
- `type_sel` in 1: gate form, latched at start.
  - 0: c = ~(a|b) = ~a & ~b.
  - 1: c = ~(a&b) = ~a | ~b.
- `dut_c` in 1: gate output under test.
- `dut_a` out 1: gate input a, registered.
- `dut_b` out 1: gate input b, registered.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `pass` out 1: 1 when the last run had zero mismatches; held until next start.
- `err_cnt` out ERR_W: mismatches in the last or current run; saturating.

## Operation
- States:
  - IDLE: `busy`=0, `dut_a`=`dut_b`=0.
  - SETTLE: vector driven; settle counter running.
  - SAMPLE: `dut_c` compared on this cycle's closing edge.
  - DONE: `done`=1 for one cycle, then back to IDLE.
- IDLE→SETTLE when `start`=1. On the same edge:
  - `vec` is set to 0 and the settle counter to 0.
  - `err_cnt` and `pass` are cleared.
  - `type_sel` is latched.
  - `busy` is set to 1.
- SETTLE→SAMPLE when the settle counter reaches SETTLE_CYCLES-1; otherwise the counter increments.
- SAMPLE:
  - Expected value is computed from {dut_a, dut_b} and the latched type.
  - A mismatch increments `err_cnt`, saturating at 2^ERR_W-1.
  - If this is the last vector of the last pass: go to DONE.
  - Otherwise: `vec` increments (wrapping 3→0 and advancing the pass counter), then go to SETTLE.
- DONE: `busy`=0, `pass`=(err_cnt==0 including the final sample), then IDLE.
- `{dut_a, dut_b}` = `vec` at all times during SETTLE and SAMPLE.
- `start` while busy or in DONE is ignored; a start held high in IDLE re-launches immediately.
- `type_sel` changes during a run have no effect.
- An `rst_n` assertion mid-run aborts asynchronously to IDLE. All outputs go to 0 and no `done` is issued.

## Timing
- Reset value of all outputs: 0.
- Each vector is held for SETTLE_CYCLES+1 cycles.
- `busy` is high for exactly 4·PASSES·(SETTLE_CYCLES+1) cycles, starting the cycle after the `start` edge.
- `done` is high the single cycle immediately after `busy` falls.
- `dut_c` is sampled (SETTLE_CYCLES+1) cycles after its vector is applied. The DUT path must settle within SETTLE_CYCLES·T_clk.
- `err_cnt` updates the cycle after each SAMPLE. `pass` is valid from the `done` cycle.

## Configuration
- `DEMORGAN_CHK_HALT_ON_ERR_EN`
  - Defined: the first mismatch goes SAMPLE→DONE directly. `done` pulses, `err_cnt`=1, `pass`=0, and `dut_a`/`dut_b` return to 0 in IDLE.
  - Undefined: the run always completes the full sweep and counts every mismatch.

## Structure
- Package `demorgan_chk_pkg` holds:
  - The state encoding: IDLE, SETTLE, SAMPLE, DONE.
  - Constants `NUM_VECTORS`=4, `TYPE_NOR_FORM`=0, `TYPE_NAND_FORM`=1.
- One sub-module, `demorgan_ref_model`: combinational expected-output function of (a, b, type). It is reused by benches as the golden model.
- Top level holds the FSM, vector/pass counters, settle counter, and error counter.

## Test plan
- Defaults, type_sel=1, DUT is a correct NAND-form gate, `start` pulsed:
  - Expected: `dut_a`/`dut_b` step through 00, 01, 10, 11 with 3 cycles each.
  - Expected: `busy` high for 12 cycles, then `done`=1, `pass`=1, `err_cnt`=0.
- type_sel=0 against the same NAND-form DUT:
  - Expected: mismatches at ab=01 and ab=10.
  - Expected: `err_cnt`=2, `pass`=0.
- DUT output tied to 0, type_sel=1, PASSES=3:
  - Expected: 3 mismatches per pass, so `err_cnt`=9 and `busy` high for 36 cycles.
- ERR_W=2, DUT tied wrong on every vector, PASSES=2:
  - Expected: `err_cnt` saturates at 3, `pass`=0.
- `rst_n` pulled low at cycle 5 of a run:
  - Expected: all outputs 0 immediately, no `done`.
  - Expected: a new `start` yields a clean full run.
- `DEMORGAN_CHK_HALT_ON_ERR_EN` defined, DUT wrong only at ab=10:
  - Expected: `done` at the cycle after vector 2's SAMPLE, `err_cnt`=1, `pass`=0.
